axil_mem_slave: RTL and testbench

AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

---
 rtl/axil_pkg.sv | 26 ++
 rtl/axil_mem_slave_if.sv | 46 ++++
 rtl/axil_mem_array.sv | 44 ++++
 rtl/axil_mem_slave.sv | 174 +++++++++++++++++
 tb/tb_axil_mem_slave.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axil_pkg
//  Brief    : Shared response encoding and write-path state type for the
//             AXI4-Lite memory slave.
//  Revision : 1.0
// ============================================================================
package axil_pkg;

    localparam int RESP_W = 2;

    typedef enum logic [RESP_W-1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    // Write path: which holding register is full, or a B response is pending.
    typedef enum logic [1:0] {
        WR_IDLE    = 2'b00,
        WR_HAVE_AW = 2'b01,
        WR_HAVE_W  = 2'b10,
        WR_RESP    = 2'b11
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_mem_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : axil_mem_slave_if
//  Brief    : AXI4-Lite bus bundle with master and slave modports.
//  Revision : 1.0
// ============================================================================
interface axil_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    import axil_pkg::*;

    logic                  AXI_AWVALID;
    logic                  AXI_AWREADY;
    logic [ADDR_W-1:0]     AXI_AWADDR;
    logic                  AXI_WVALID;
    logic                  AXI_WREADY;
    logic [DATA_W-1:0]     AXI_WDATA;
    logic [DATA_W/8-1:0]   AXI_WSTRB;
    logic                  AXI_BVALID;
    logic                  AXI_BREADY;
    logic [RESP_W-1:0]     AXI_BRESP;
    logic                  AXI_ARVALID;
    logic                  AXI_ARREADY;
    logic [ADDR_W-1:0]     AXI_ARADDR;
    logic                  AXI_RVALID;
    logic                  AXI_RREADY;
    logic [DATA_W-1:0]     AXI_RDATA;
    logic [RESP_W-1:0]     AXI_RRESP;

    modport slave (
        input  AXI_AWVALID, AXI_AWADDR, AXI_WVALID, AXI_WDATA, AXI_WSTRB,
               AXI_BREADY, AXI_ARVALID, AXI_ARADDR, AXI_RREADY,
        output AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP,
               AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
    );

    modport master (
        output AXI_AWVALID, AXI_AWADDR, AXI_WVALID, AXI_WDATA, AXI_WSTRB,
               AXI_BREADY, AXI_ARVALID, AXI_ARADDR, AXI_RREADY,
        input  AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP,
               AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
    );

endinterface
`default_nettype wire

// File: rtl/axil_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : axil_mem_array
//  Brief    : DEPTH x DATA_W storage, one byte-enabled write port and one
//             registered read port. Contents are never reset.
//  Revision : 1.0
// ============================================================================
module axil_mem_array #(
    parameter  int DEPTH  = 256,
    parameter  int DATA_W = 32,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read samples the pre-write value when both ports hit the same word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axil_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axil_mem_slave
//  Brief    : AXI4-Lite memory slave with independent AW/W capture, one
//             outstanding write and single-cycle pipelined reads.
//  Revision : 1.0
// ============================================================================
module axil_mem_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic            AXI_ACLK,
    input  logic            AXI_ARESETN,
    axil_mem_slave_if.slave axi
);
    import axil_pkg::*;

    localparam int c_strb_w = DATA_W / 8;
    localparam int c_lsb    = $clog2(c_strb_w);
    localparam int c_idx_w  = $clog2(DEPTH);
    localparam int c_hi     = c_lsb + c_idx_w;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> c_hi) == '0;
    endfunction

    wr_state_t             r_wr_state;
    wr_state_t             w_wr_next;
    logic                  r_ready_en;
    logic                  w_awready;
    logic                  w_wready;
    logic                  w_commit;
    logic                  w_mem_we;
    logic [ADDR_W-1:0]     r_aw_addr;
    logic [ADDR_W-1:0]     w_cm_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     w_cm_data;
    logic [c_strb_w-1:0]   r_wstrb;
    logic [c_strb_w-1:0]   w_cm_strb;
    resp_t                 r_bresp;
    logic                  w_arready;
    logic                  w_ar_hs;
    logic                  r_rvalid;
    resp_t                 r_rresp;
    logic [DATA_W-1:0]     w_mem_rdata;

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
        end
    end

    // The write commits on the edge that completes the AW/W pair.
    always_comb begin
        w_wr_next = r_wr_state;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_commit  = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_awready = r_ready_en;
                w_wready  = r_ready_en;
                if (r_ready_en && axi.AXI_AWVALID && axi.AXI_WVALID) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end else if (r_ready_en && axi.AXI_AWVALID) begin
                    w_wr_next = WR_HAVE_AW;
                end else if (r_ready_en && axi.AXI_WVALID) begin
                    w_wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                w_wready = 1'b1;
                if (axi.AXI_WVALID) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                w_awready = 1'b1;
                if (axi.AXI_AWVALID) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.AXI_BREADY) begin
                    w_wr_next = WR_IDLE;
                end
            end
            default: begin
                w_wr_next = WR_IDLE;
            end
        endcase
    end

    assign w_cm_addr = (r_wr_state == WR_HAVE_AW) ? r_aw_addr : axi.AXI_AWADDR;
    assign w_cm_data = (r_wr_state == WR_HAVE_W)  ? r_wdata   : axi.AXI_WDATA;
    assign w_cm_strb = (r_wr_state == WR_HAVE_W)  ? r_wstrb   : axi.AXI_WSTRB;
    assign w_mem_we  = w_commit && in_range(w_cm_addr);

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_aw_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= OKAY;
        end else begin
            if (w_awready && axi.AXI_AWVALID) begin
                r_aw_addr <= axi.AXI_AWADDR;
            end
            if (w_wready && axi.AXI_WVALID) begin
                r_wdata <= axi.AXI_WDATA;
                r_wstrb <= axi.AXI_WSTRB;
            end
            if (w_commit) begin
                r_bresp <= in_range(w_cm_addr) ? OKAY : SLVERR;
            end
        end
    end

    assign w_arready = r_ready_en && (!r_rvalid || axi.AXI_RREADY);
    assign w_ar_hs   = w_arready && axi.AXI_ARVALID;

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rresp  <= OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= in_range(axi.AXI_ARADDR) ? OKAY : SLVERR;
        end else if (axi.AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    axil_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (AXI_ACLK),
        .i_we    (w_mem_we),
        .i_waddr (w_cm_addr[c_lsb +: c_idx_w]),
        .i_wstrb (w_cm_strb),
        .i_wdata (w_cm_data),
        .i_re    (w_ar_hs),
        .i_raddr (axi.AXI_ARADDR[c_lsb +: c_idx_w]),
        .o_rdata (w_mem_rdata)
    );

    assign axi.AXI_AWREADY = w_awready;
    assign axi.AXI_WREADY  = w_wready;
    assign axi.AXI_BVALID  = (r_wr_state == WR_RESP);
    assign axi.AXI_BRESP   = r_bresp;
    assign axi.AXI_ARREADY = w_arready;
    assign axi.AXI_RVALID  = r_rvalid;
    assign axi.AXI_RRESP   = r_rresp;
    // Error reads and idle cycles present zero data.
    assign axi.AXI_RDATA   = (r_rvalid && (r_rresp == OKAY)) ? w_mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_axil_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_mem_slave
//  Brief    : Self-checking bench for axil_mem_slave against a word-array model.
//  Revision : 1.0
// ============================================================================
module tb_axil_mem_slave;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    axil_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axil_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256)) dut (
        .AXI_ACLK    (clk),
        .AXI_ARESETN (rst_n),
        .axi         (axi)
    );

    // 256 words of 4 bytes: byte addresses 0x000..0x3FF are backed.
    function automatic bit ref_oor(input logic [31:0] a);
        return a >= 32'h400;
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'(a / 4);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!ref_oor(a)) begin
            w = ref_mem.exists(ref_idx(a)) ? ref_mem[ref_idx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            ref_mem[ref_idx(a)] = w;
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_oor(a)) return 32'h0;
        return ref_mem[ref_idx(a)];
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, b_done, aw_hs, w_hs, b_hs;
        int cyc;
        aw_done = 0; w_done = 0; b_done = 0; cyc = 0; resp = 2'b01;
        axi.AXI_AWADDR = a; axi.AXI_WDATA = d; axi.AXI_WSTRB = s; axi.AXI_BREADY = 1'b1;
        while (!b_done && cyc < 30) begin
            axi.AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            axi.AXI_WVALID  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            aw_hs = axi.AXI_AWVALID && axi.AXI_AWREADY;
            w_hs  = axi.AXI_WVALID && axi.AXI_WREADY;
            b_hs  = axi.AXI_BVALID && axi.AXI_BREADY;
            if (b_hs) resp = axi.AXI_BRESP;
            @(posedge clk); #1;
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            b_done  = b_done | b_hs;
            cyc++;
        end
        axi.AXI_AWVALID = 1'b0; axi.AXI_WVALID = 1'b0; axi.AXI_BREADY = 1'b0;
        ok = b_done;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
        bit ar_done, r_done, ar_hs, r_hs;
        int cyc;
        ar_done = 0; r_done = 0; cyc = 0; data = 32'hx; resp = 2'b01;
        axi.AXI_ARADDR = a; axi.AXI_RREADY = 1'b1;
        while (!r_done && cyc < 30) begin
            axi.AXI_ARVALID = !ar_done;
            @(negedge clk);
            ar_hs = axi.AXI_ARVALID && axi.AXI_ARREADY;
            r_hs  = ar_done && axi.AXI_RVALID && axi.AXI_RREADY;
            if (r_hs) begin data = axi.AXI_RDATA; resp = axi.AXI_RRESP; end
            @(posedge clk); #1;
            ar_done = ar_done | ar_hs;
            r_done  = r_done | r_hs;
            cyc++;
        end
        axi.AXI_ARVALID = 1'b0; axi.AXI_RREADY = 1'b0;
        ok = r_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY, axi.AXI_BVALID, axi.AXI_RVALID} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY, axi.AXI_BVALID, axi.AXI_RVALID}); end
        n_checks++; if ({axi.AXI_BRESP, axi.AXI_RRESP, axi.AXI_RDATA} !== 36'h0) begin n_fail++; $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h want 0", axi.AXI_BRESP, axi.AXI_RRESP, axi.AXI_RDATA); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY} !== 3'b000) begin n_fail++; $display("FAIL release_early: got %b want 000", {axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY}); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if ({axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY} !== 3'b111) begin n_fail++; $display("FAIL release_ready: got %b want 111", {axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY}); end
        @(posedge clk); #1;
    endtask

    task automatic test_aligned();
        axi.AXI_AWADDR = 32'h10; axi.AXI_WDATA = 32'hDEADBEEF; axi.AXI_WSTRB = 4'hF;
        axi.AXI_AWVALID = 1'b1; axi.AXI_WVALID = 1'b1; axi.AXI_BREADY = 1'b1;
        @(negedge clk);
        n_checks++; if ({axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_BVALID} !== 3'b110) begin n_fail++; $display("FAIL aligned_accept: got %b want 110", {axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_BVALID}); end
        @(posedge clk); #1;
        axi.AXI_AWVALID = 1'b0; axi.AXI_WVALID = 1'b0;
        @(negedge clk);
        n_checks++; if ({axi.AXI_BVALID, axi.AXI_BRESP} !== 3'b100) begin n_fail++; $display("FAIL aligned_b: got bvalid=%b bresp=%b want 1/00", axi.AXI_BVALID, axi.AXI_BRESP); end
        @(posedge clk); #1;
        axi.AXI_BREADY = 1'b0;
        ref_write(32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        n_checks++; if ({axi.AXI_BVALID, axi.AXI_AWREADY, axi.AXI_WREADY} !== 3'b011) begin n_fail++; $display("FAIL aligned_b_done: got %b want 011", {axi.AXI_BVALID, axi.AXI_AWREADY, axi.AXI_WREADY}); end
        @(posedge clk); #1;
        axi.AXI_ARADDR = 32'h10; axi.AXI_ARVALID = 1'b1; axi.AXI_RREADY = 1'b1;
        @(negedge clk);
        n_checks++; if ({axi.AXI_ARREADY, axi.AXI_RVALID} !== 2'b10) begin n_fail++; $display("FAIL aligned_ar: got %b want 10", {axi.AXI_ARREADY, axi.AXI_RVALID}); end
        @(posedge clk); #1;
        axi.AXI_ARVALID = 1'b0;
        @(negedge clk);
        n_checks++; if ({axi.AXI_RVALID, axi.AXI_RRESP, axi.AXI_RDATA} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin n_fail++; $display("FAIL aligned_r: got v=%b resp=%b data=%h want 1/00/deadbeef", axi.AXI_RVALID, axi.AXI_RRESP, axi.AXI_RDATA); end
        @(posedge clk); #1;
        axi.AXI_RREADY = 1'b0;
        @(negedge clk);
        n_checks++; if ({axi.AXI_RVALID, axi.AXI_RDATA} !== 33'h0) begin n_fail++; $display("FAIL aligned_r_idle: got v=%b data=%h want 0/0", axi.AXI_RVALID, axi.AXI_RDATA); end
        @(posedge clk); #1;
    endtask

    task automatic test_strobes();
        logic [1:0] resp; logic [31:0] data; bit ok;
        do_write(32'h20, 32'h11223344, 4'hF, 0, 0, resp, ok);
        ref_write(32'h20, 32'h11223344, 4'hF);
        do_write(32'h20, 32'hAABBCCDD, 4'h5, 0, 0, resp, ok);
        ref_write(32'h20, 32'hAABBCCDD, 4'h5);
        n_checks++; if (!ok || resp !== 2'b00) begin n_fail++; $display("FAIL strobe_write: got ok=%0d resp=%b want 1/00", ok, resp); end
        do_read(32'h20, data, resp, ok);
        n_checks++; if (!ok || data !== 32'h11BB33DD || data !== ref_read(32'h20)) begin n_fail++; $display("FAIL strobe_read: got ok=%0d data=%h want 11bb33dd", ok, data); end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d, data; logic [1:0] resp; bit ok;
        d = $urandom;
        axi.AXI_WDATA = d; axi.AXI_WSTRB = 4'hF; axi.AXI_WVALID = 1'b1; axi.AXI_BREADY = 1'b0;
        @(negedge clk);
        n_checks++; if (axi.AXI_WREADY !== 1'b1) begin n_fail++; $display("FAIL wfirst_c0: got wready=%b want 1", axi.AXI_WREADY); end
        @(posedge clk); #1;
        axi.AXI_WVALID = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin axi.AXI_AWADDR = 32'h28; axi.AXI_AWVALID = 1'b1; end
            @(negedge clk);
            n_checks++; if ({axi.AXI_WREADY, axi.AXI_AWREADY, axi.AXI_BVALID} !== 3'b010) begin n_fail++; $display("FAIL wfirst_c%0d: got wr/awr/bv=%b want 010", c, {axi.AXI_WREADY, axi.AXI_AWREADY, axi.AXI_BVALID}); end
            @(posedge clk); #1;
        end
        axi.AXI_AWVALID = 1'b0;
        ref_write(32'h28, d, 4'hF);
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk);
            n_checks++; if ({axi.AXI_BVALID, axi.AXI_BRESP, axi.AXI_AWREADY, axi.AXI_WREADY} !== 5'b10000) begin n_fail++; $display("FAIL wfirst_b_c%0d: got bv/bresp/awr/wr=%b want 10000", c, {axi.AXI_BVALID, axi.AXI_BRESP, axi.AXI_AWREADY, axi.AXI_WREADY}); end
            @(posedge clk); #1;
        end
        axi.AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        axi.AXI_BREADY = 1'b0;
        @(negedge clk);
        n_checks++; if ({axi.AXI_BVALID, axi.AXI_AWREADY, axi.AXI_WREADY} !== 3'b011) begin n_fail++; $display("FAIL wfirst_release: got %b want 011", {axi.AXI_BVALID, axi.AXI_AWREADY, axi.AXI_WREADY}); end
        @(posedge clk); #1;
        do_read(32'h28, data, resp, ok);
        n_checks++; if (!ok || data !== ref_read(32'h28)) begin n_fail++; $display("FAIL wfirst_read: got ok=%0d data=%h want %h", ok, data, ref_read(32'h28)); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, exp; logic [1:0] resp; bit ok;
        d = $urandom;
        do_write(32'h4, d, 4'hF, 1, 0, resp, ok);
        ref_write(32'h4, d, 4'hF);
        exp = ref_read(32'h4);
        axi.AXI_ARADDR = 32'h4; axi.AXI_ARVALID = 1'b1; axi.AXI_RREADY = 1'b0;
        @(negedge clk);
        n_checks++; if (axi.AXI_ARREADY !== 1'b1) begin n_fail++; $display("FAIL bp_ar: got arready=%b want 1", axi.AXI_ARREADY); end
        @(posedge clk); #1;
        axi.AXI_ARVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if ({axi.AXI_RVALID, axi.AXI_ARREADY, axi.AXI_RDATA} !== {1'b1, 1'b0, exp}) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b arr=%b data=%h want 1/0/%h", c, axi.AXI_RVALID, axi.AXI_ARREADY, axi.AXI_RDATA, exp); end
            @(posedge clk); #1;
        end
        axi.AXI_RREADY = 1'b1;
        @(negedge clk);
        n_checks++; if ({axi.AXI_RVALID, axi.AXI_ARREADY} !== 2'b11) begin n_fail++; $display("FAIL bp_release: got v/arr=%b want 11", {axi.AXI_RVALID, axi.AXI_ARREADY}); end
        @(posedge clk); #1;
        axi.AXI_RREADY = 1'b0;
        @(negedge clk);
        n_checks++; if ({axi.AXI_RVALID, axi.AXI_RDATA} !== 33'h0) begin n_fail++; $display("FAIL bp_done: got v=%b data=%h want 0/0", axi.AXI_RVALID, axi.AXI_RDATA); end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d, data; logic [1:0] resp; bit ok;
        d = $urandom;
        do_write(32'h0, d, 4'hF, 0, 0, resp, ok);
        ref_write(32'h0, d, 4'hF);
        do_write(32'h400, ~d, 4'hF, 0, 0, resp, ok);
        ref_write(32'h400, ~d, 4'hF);
        n_checks++; if (!ok || resp !== 2'b10) begin n_fail++; $display("FAIL oor_bresp: got ok=%0d resp=%b want 1/10", ok, resp); end
        do_read(32'h0, data, resp, ok);
        n_checks++; if (!ok || data !== ref_read(32'h0) || resp !== 2'b00) begin n_fail++; $display("FAIL oor_alias: got data=%h resp=%b want %h/00", data, resp, ref_read(32'h0)); end
        do_read(32'h400, data, resp, ok);
        n_checks++; if (!ok || data !== 32'h0 || resp !== 2'b10) begin n_fail++; $display("FAIL oor_read: got data=%h resp=%b want 0/10", data, resp); end
    endtask

    task automatic test_collision();
        logic [31:0] old_d, new_d, data; logic [1:0] resp; bit ok;
        old_d = $urandom; new_d = ~old_d;
        do_write(32'h14, old_d, 4'hF, 0, 0, resp, ok);
        ref_write(32'h14, old_d, 4'hF);
        axi.AXI_AWADDR = 32'h14; axi.AXI_WDATA = new_d; axi.AXI_WSTRB = 4'hF; axi.AXI_ARADDR = 32'h14;
        axi.AXI_AWVALID = 1'b1; axi.AXI_WVALID = 1'b1; axi.AXI_ARVALID = 1'b1;
        axi.AXI_BREADY = 1'b1; axi.AXI_RREADY = 1'b1;
        @(negedge clk);
        n_checks++; if ({axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY} !== 3'b111) begin n_fail++; $display("FAIL coll_ready: got %b want 111", {axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY}); end
        @(posedge clk); #1;
        axi.AXI_AWVALID = 1'b0; axi.AXI_WVALID = 1'b0; axi.AXI_ARVALID = 1'b0;
        @(negedge clk);
        n_checks++; if ({axi.AXI_RVALID, axi.AXI_BVALID, axi.AXI_RDATA} !== {2'b11, ref_read(32'h14)}) begin n_fail++; $display("FAIL coll_old: got rv=%b bv=%b data=%h want 1/1/%h", axi.AXI_RVALID, axi.AXI_BVALID, axi.AXI_RDATA, ref_read(32'h14)); end
        @(posedge clk); #1;
        axi.AXI_BREADY = 1'b0; axi.AXI_RREADY = 1'b0;
        ref_write(32'h14, new_d, 4'hF);
        do_read(32'h14, data, resp, ok);
        n_checks++; if (!ok || data !== ref_read(32'h14)) begin n_fail++; $display("FAIL coll_new: got data=%h want %h", data, ref_read(32'h14)); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d, data; logic [1:0] resp; bit ok;
        d = $urandom;
        do_write(32'h30, d, 4'hF, 0, 0, resp, ok);
        ref_write(32'h30, d, 4'hF);
        axi.AXI_AWADDR = 32'h30; axi.AXI_AWVALID = 1'b1;
        axi.AXI_WDATA = ~d; axi.AXI_WSTRB = 4'hF;
        @(posedge clk); #1;
        axi.AXI_AWVALID = 1'b0;
        @(negedge clk);
        n_checks++; if ({axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_BVALID} !== 3'b010) begin n_fail++; $display("FAIL mid_aw_held: got %b want 010", {axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_BVALID}); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY, axi.AXI_BVALID} !== 4'b0) begin n_fail++; $display("FAIL mid_in_reset: got %b want 0000", {axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY, axi.AXI_BVALID}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi.AXI_BREADY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ({axi.AXI_BVALID, axi.AXI_AWREADY, axi.AXI_WREADY} !== 3'b011) begin n_fail++; $display("FAIL mid_no_b%0d: got bv/awr/wr=%b want 011", c, {axi.AXI_BVALID, axi.AXI_AWREADY, axi.AXI_WREADY}); end
            @(posedge clk); #1;
        end
        axi.AXI_BREADY = 1'b0;
        do_read(32'h30, data, resp, ok);
        n_checks++; if (!ok || data !== ref_read(32'h30)) begin n_fail++; $display("FAIL mid_prior: got data=%h want %h", data, ref_read(32'h30)); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, data; logic [3:0] s; logic [1:0] resp, exp_resp; bit ok;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_write(32'(i * 4), d, 4'hF, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, ok);
            ref_write(32'(i * 4), d, 4'hF);
            n_checks++; if (!ok || resp !== 2'b00) begin n_fail++; $display("FAIL rnd_init%0d: got ok=%0d resp=%b want 1/00", i, ok, resp); end
        end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) a = 32'h400 + ($urandom & 32'h0FFF_FFFF);
            else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            exp_resp = ref_oor(a) ? 2'b10 : 2'b00;
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom; s = 4'($urandom);
                do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, ok);
                ref_write(a, d, s);
                n_checks++; if (!ok || resp !== exp_resp) begin n_fail++; $display("FAIL rnd_wr%0d: addr=%h got ok=%0d resp=%b want %b", i, a, ok, resp, exp_resp); end
            end else begin
                do_read(a, data, resp, ok);
                n_checks++; if (!ok || resp !== exp_resp || data !== ref_read(a)) begin n_fail++; $display("FAIL rnd_rd%0d: addr=%h got ok=%0d resp=%b data=%h want %b/%h", i, a, ok, resp, data, exp_resp, ref_read(a)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6];
        for (int i = 0; i < 6; i++) addrs[i] = 32'($urandom_range(0, 15)) << 2;
        axi.AXI_RREADY = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            axi.AXI_ARVALID = (c < 6);
            axi.AXI_ARADDR  = (c < 6) ? addrs[c] : 32'h0;
            @(negedge clk);
            if (c < 6) begin
                n_checks++; if (axi.AXI_ARREADY !== 1'b1) begin n_fail++; $display("FAIL b2b_arready%0d: got %b want 1", c, axi.AXI_ARREADY); end
            end
            if (c > 0) begin
                n_checks++; if ({axi.AXI_RVALID, axi.AXI_RDATA} !== {1'b1, ref_read(addrs[c-1])}) begin n_fail++; $display("FAIL b2b_data%0d: got v=%b data=%h want 1/%h", c, axi.AXI_RVALID, axi.AXI_RDATA, ref_read(addrs[c-1])); end
            end
            @(posedge clk); #1;
        end
        axi.AXI_ARVALID = 1'b0; axi.AXI_RREADY = 1'b0;
        @(negedge clk);
        n_checks++; if (axi.AXI_RVALID !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got rvalid=%b want 0", axi.AXI_RVALID); end
        @(posedge clk); #1;
    endtask

    initial begin
        axi.AXI_AWVALID = 1'b0; axi.AXI_AWADDR = '0;
        axi.AXI_WVALID = 1'b0; axi.AXI_WDATA = '0; axi.AXI_WSTRB = '0;
        axi.AXI_BREADY = 1'b0;
        axi.AXI_ARVALID = 1'b0; axi.AXI_ARADDR = '0;
        axi.AXI_RREADY = 1'b0;
        test_reset();
        test_aligned();
        test_strobes();
        test_w_before_aw();
        test_backpressure();
        test_out_of_range();
        test_collision();
        test_reset_mid_write();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
